// File: rtl/fir_out_requant.sv
// FIR output requantiser: decimate, round-half-up shift, saturate, then buffer in a small FIFO.
// Define FIR_OUT_REQUANT_STATS_EN to build the saturation event counter (sat_cnt).
module fir_out_requant #(
   parameter int WIDTH_IN  = 20,
   parameter int WIDTH_OUT = 8,
   parameter int SHIFT     = 8,
   parameter int DECIM     = 4,
   parameter int DEPTH     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 x_valid,
   input  logic [WIDTH_IN-1:0]  x,
   output logic                 y_valid,
   input  logic                 y_ready,
   output logic [WIDTH_OUT-1:0] y,
   output logic                 sat_flag,
   output logic                 ovf,
   output logic [15:0]          drop_cnt,
   output logic [15:0]          sat_cnt
);

   localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);
   localparam logic [AW:0]   CNT_FULL   = (AW+1)'(DEPTH);
   localparam logic signed [WIDTH_IN:0] RND  = (WIDTH_IN+1)'((2**SHIFT) >> 1);
   localparam logic signed [WIDTH_IN:0] MAXV = (WIDTH_IN+1)'((2**(WIDTH_OUT-1)) - 1);
   localparam logic signed [WIDTH_IN:0] MINV = (WIDTH_IN+1)'(-(2**(WIDTH_OUT-1)));

   logic [PW-1:0]              phase;
   logic                       keep;
   logic signed [WIDTH_IN:0]   t;
   logic signed [WIDTH_IN:0]   r;
   logic                       sat_hi;
   logic                       sat_lo;
   logic [WIDTH_OUT-1:0]       q;

   logic                       s1_valid;
   logic                       s1_sat;
   logic [WIDTH_OUT-1:0]       s1_data;

   logic [WIDTH_OUT-1:0]       mem [DEPTH];
   logic [AW-1:0]              wptr;
   logic [AW-1:0]              rptr;
   logic [AW:0]                count;
   logic                       full;
   logic                       pop;
   logic                       wr;
   logic                       drop;

   assign keep = x_valid && (phase == '0);

   // One extra bit of headroom so the rounding add cannot wrap.
   assign t      = $signed({x[WIDTH_IN-1], x}) + RND;
   assign r      = t >>> SHIFT;
   assign sat_hi = (r > MAXV);
   assign sat_lo = (r < MINV);
   assign q      = sat_hi ? MAXV[WIDTH_OUT-1:0] :
                   sat_lo ? MINV[WIDTH_OUT-1:0] : r[WIDTH_OUT-1:0];

   assign full    = (count == CNT_FULL);
   assign y_valid = (count != '0);
   assign pop     = y_valid && y_ready;
   assign wr      = s1_valid && (!full || pop);
   assign drop    = s1_valid && full && !pop;
   assign y       = y_valid ? mem[rptr] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase    <= '0;
         s1_valid <= 1'b0;
         s1_sat   <= 1'b0;
         s1_data  <= '0;
      end else if (clr) begin
         phase    <= '0;
         s1_valid <= 1'b0;
         s1_sat   <= 1'b0;
         s1_data  <= '0;
      end else begin
         if (x_valid) begin
            phase <= (phase == PHASE_LAST) ? '0 : phase + PW'(1);
         end
         s1_valid <= keep;
         s1_sat   <= keep && (sat_hi || sat_lo);
         if (keep) begin
            s1_data <= q;
         end
      end
   end

   // Entry storage is left unreset; y is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (wr) begin
         mem[wptr] <= s1_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         ovf      <= 1'b0;
         drop_cnt <= '0;
         sat_flag <= 1'b0;
      end else if (clr) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         ovf      <= 1'b0;
         drop_cnt <= '0;
         sat_flag <= 1'b0;
      end else begin
         if (wr) begin
            wptr <= wptr + AW'(1);
         end
         if (pop) begin
            rptr <= rptr + AW'(1);
         end
         case ({wr, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         ovf <= drop;
         if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
         end
         if (s1_valid && s1_sat) begin
            sat_flag <= 1'b1;
         end
      end
   end

`ifdef FIR_OUT_REQUANT_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_cnt <= '0;
      end else if (clr) begin
         sat_cnt <= '0;
      end else if (s1_valid && s1_sat && (sat_cnt != 16'hFFFF)) begin
         sat_cnt <= sat_cnt + 16'd1;
      end
   end
`else
   assign sat_cnt = '0;
`endif

endmodule

// File: tb/tb_fir_out_requant.sv
// Directed bench for fir_out_requant at default parameters (DECIM=4, SHIFT=8, DEPTH=4).
module tb_fir_out_requant;

   logic              clk = 1'b0;
   logic              rst;
   logic              clr;
   logic              x_valid;
   logic [19:0]       x;
   logic              y_valid;
   logic              y_ready;
   logic signed [7:0] y;
   logic              sat_flag;
   logic              ovf;
   logic [15:0]       drop_cnt;
   logic [15:0]       sat_cnt;

   int total = 0;
   int bad   = 0;
   int exp_q[$];
   int n_ovf;
   int exp_sat_cnt;

   fir_out_requant dut (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .x_valid  (x_valid),
      .x        (x),
      .y_valid  (y_valid),
      .y_ready  (y_ready),
      .y        (y),
      .sat_flag (sat_flag),
      .ovf      (ovf),
      .drop_cnt (drop_cnt),
      .sat_cnt  (sat_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input int val);
      x_valid = v;
      x       = 20'(val);
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   // One kept sample followed by three discarded ones, so phase returns to 0.
   task automatic send_kept(input int val);
      drive(1'b1, val);
      tick();
      repeat (3) begin
         drive(1'b1, 0);
         tick();
      end
      drive(1'b0, 0);
   endtask

   task automatic observe();
      if (y_valid && y_ready) begin
         if (exp_q.size() == 0) chk("extra_out", y, 999);
         else chk("dec_out", y, exp_q.pop_front());
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rin[4];
      int rexp[4];
      rin  = '{384, 383, -384, -385};
      rexp = '{2, 1, -1, -2};
`ifdef FIR_OUT_REQUANT_STATS_EN
      exp_sat_cnt = 2;
`else
      exp_sat_cnt = 0;
`endif
      rst = 1'b1; clr = 1'b0; x_valid = 1'b0; x = '0; y_ready = 1'b0;
      #2;
      chk("rst_y_valid", y_valid, 0);
      chk("rst_y", y, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_sat_flag", sat_flag, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      chk("rst_sat_cnt", sat_cnt, 0);
      #10 rst = 1'b0;
      tick();

      // rounding: result visible two edges after the input, not one
      y_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         do_clr();
         drive(1'b1, rin[i]);
         tick();
         drive(1'b0, 0);
         chk("round_lat1", y_valid, 0);
         tick();
         chk("round_valid", y_valid, 1);
         chk("round_y", y, rexp[i]);
         tick();
         chk("round_empty", y_valid, 0);
      end

      // saturation both ways
      do_clr();
      y_ready = 1'b0;
      send_kept(40000);
      send_kept(-40000);
      chk("sat_valid", y_valid, 1);
      chk("sat_hi_y", y, 127);
      chk("sat_flag", sat_flag, 1);
      chk("sat_cnt", sat_cnt, exp_sat_cnt);
      y_ready = 1'b1;
      tick();
      chk("sat_lo_y", y, -128);
      tick();
      chk("sat_empty", y_valid, 0);
      chk("sat_flag_sticky", sat_flag, 1);

      // decimation, continuous input
      do_clr();
      exp_q = '{0, 4, 8, 12};
      for (int k = 0; k < 16; k++) begin
         drive(1'b1, 256 * k);
         tick();
         observe();
      end
      drive(1'b0, 0);
      repeat (4) begin
         tick();
         observe();
      end
      chk("dec_cont_left", exp_q.size(), 0);
      chk("dec_cont_end", y_valid, 0);

      // decimation, every other cycle
      do_clr();
      exp_q = '{0, 4, 8, 12};
      for (int k = 0; k < 16; k++) begin
         drive(1'b1, 256 * k);
         tick();
         observe();
         drive(1'b0, 0);
         tick();
         observe();
      end
      repeat (4) begin
         tick();
         observe();
      end
      chk("dec_gap_left", exp_q.size(), 0);
      chk("dec_gap_end", y_valid, 0);

      // backpressure and overflow
      do_clr();
      y_ready = 1'b0;
      n_ovf = 0;
      for (int k = 0; k < 24; k++) begin
         drive(1'b1, 256 * k);
         tick();
         if (ovf) n_ovf++;
      end
      drive(1'b0, 0);
      repeat (3) begin
         tick();
         if (ovf) n_ovf++;
      end
      chk("bp_ovf_pulses", n_ovf, 2);
      chk("bp_drop_cnt", drop_cnt, 2);
      chk("bp_y_valid", y_valid, 1);
      chk("bp_y_held", y, 0);
      y_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("bp_drain_valid", y_valid, 1);
         chk("bp_drain_y", y, 4 * i);
         tick();
      end
      chk("bp_drain_end", y_valid, 0);
      chk("bp_drop_keep", drop_cnt, 2);

      // full FIFO with a pop in the same cycle as the S1 write
      do_clr();
      y_ready = 1'b0;
      for (int i = 1; i <= 4; i++) send_kept(256 * i);
      drive(1'b1, 256 * 5);
      tick();
      drive(1'b0, 0);
      y_ready = 1'b1;
      tick();
      y_ready = 1'b0;
      chk("fp_ovf", ovf, 0);
      chk("fp_drop_cnt", drop_cnt, 0);
      chk("fp_head", y, 2);
      tick();
      chk("fp_ovf_late", ovf, 0);
      exp_q = '{2, 3, 4, 5};
      y_ready = 1'b1;
      repeat (4) begin
         observe();
         tick();
      end
      chk("fp_left", exp_q.size(), 0);
      chk("fp_end", y_valid, 0);

      // clr beats a simultaneous kept sample and wipes a full FIFO
      do_clr();
      y_ready = 1'b0;
      send_kept(40000);
      for (int i = 1; i <= 4; i++) send_kept(256 * i);
      chk("clr_pre_drop", drop_cnt, 1);
      chk("clr_pre_sat", sat_flag, 1);
      clr = 1'b1;
      drive(1'b1, 256 * 7);
      tick();
      clr = 1'b0;
      drive(1'b0, 0);
      chk("clr_y_valid", y_valid, 0);
      chk("clr_drop_cnt", drop_cnt, 0);
      chk("clr_sat_flag", sat_flag, 0);
      chk("clr_sat_cnt", sat_cnt, 0);
      tick();
      tick();
      chk("clr_no_keep", y_valid, 0);

      // asynchronous reset in the middle of a cycle with 3 entries held
      do_clr();
      y_ready = 1'b0;
      send_kept(40000);
      for (int i = 1; i <= 4; i++) send_kept(256 * i);
      y_ready = 1'b1;
      tick();
      y_ready = 1'b0;
      chk("ar_pre_valid", y_valid, 1);
      chk("ar_pre_y", y, 1);
      chk("ar_pre_drop", drop_cnt, 1);
      #3 rst = 1'b1;
      #1;
      chk("ar_y_valid", y_valid, 0);
      chk("ar_y", y, 0);
      chk("ar_ovf", ovf, 0);
      chk("ar_sat_flag", sat_flag, 0);
      chk("ar_drop_cnt", drop_cnt, 0);
      #2 rst = 1'b0;
      tick();
      drive(1'b1, 512);
      tick();
      drive(1'b0, 0);
      chk("ar_first_lat", y_valid, 0);
      tick();
      chk("ar_first_valid", y_valid, 1);
      chk("ar_first_y", y, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
